// File: rtl/uart_fifo.sv
// uart_fifo: buffered UART peripheral on the 8-bit memory-mapped I/O bus.
// It has a runtime-programmable baud divisor, TX and RX FIFOs and sticky
// error flags.
//
// Register map:
//   0 BAUD_LO   divisor bits [7:0]
//   1 STATUS    {00, tx_idle, parity_err, frame_err, rx_overrun, tx_space, rx_avail}
//               Writing 1 to bits 2..4 clears them.
//   2 DATA      A write pushes to TX. A read pops RX (zero-extended).
//   3 BAUD_HI   divisor bits [15:8]
//
// Ports: clk, rst (sync, active-high), address/din/w_en/r_en bus inputs,
//        dout (registered read data), rx (async serial in), tx (serial out),
//        irq (RX data pending or any sticky error).
// Optional feature: define UART_FIFO_PARITY_EN for an even-parity bit after the data.
//
// RX states  | meaning
//   RX_IDLE   | waiting for a low sample on a tick
//   RX_START  | counting to mid start bit, then re-checking the line (glitch filter)
//   RX_DATA   | sampling data bits, LSB first
//   RX_PARITY | sampling the parity bit
//   RX_STOP   | sampling the stop bit at mid-bit
//   RX_WAIT   | after a framing error, waiting for the line to return high
// TX states  | meaning
//   TX_IDLE   | nothing to send
//   TX_START  | driving the start bit
//   TX_DATA   | driving data bits, LSB first
//   TX_PARITY | driving the parity bit
//   TX_STOP   | driving the stop bit; can chain straight into the next start bit
module uart_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int BAUD_RESET = 651
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] address,
  input  logic [7:0] din,
  input  logic       w_en,
  input  logic       r_en,
  output logic [7:0] dout,
  input  logic       rx,
  output logic       tx,
  output logic       irq
);
  localparam int OW = $clog2(OVERSAMPLE);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [OW-1:0] OS_LAST  = OW'(OVERSAMPLE - 1);
  localparam logic [OW-1:0] OS_HALF  = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);
  localparam logic [PW-1:0] DEPTH    = PW'(FIFO_DEPTH);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

  logic [15:0] div_q, div_d, presc_q, presc_d;
  logic [1:0] sync_q, sync_d;
  rx_state_t rx_st_q, rx_st_d;
  tx_state_t tx_st_q, tx_st_d;
  logic [OW-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic [2:0] rx_bit_q, rx_bit_d, tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d, tx_sh_q, tx_sh_d;
  logic tx_q, tx_d, irq_q, irq_d, ovr_q, ovr_d, fe_q, fe_d, pe_q, pe_d;
  logic [7:0] dout_q, dout_d;
  logic [PW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d, rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [DATA_BITS-1:0] tx_mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0] rx_mem_q [FIFO_DEPTH];
`ifdef UART_FIFO_PARITY_EN
  logic tx_par_q, tx_par_d, rx_par_q, rx_par_d, pe_set;
`endif

  logic tick, rx_s, tx_empty, tx_full, rx_empty, rx_full, tx_idle;
  logic tx_start, tx_pop, tx_push, rx_push, rx_pop, rx_push_ok, ovr_set, fe_set;
  logic [2:0] clr;
  logic [7:0] status;

  always_comb begin
    div_d = div_q;
    sync_d = {sync_q[0], rx};
    rx_s = sync_q[1];
    rx_st_d = rx_st_q; rx_cnt_d = rx_cnt_q; rx_bit_d = rx_bit_q; rx_sh_d = rx_sh_q;
    tx_st_d = tx_st_q; tx_cnt_d = tx_cnt_q; tx_bit_d = tx_bit_q; tx_sh_d = tx_sh_q;
    tx_d = tx_q;
    dout_d = dout_q;
    rx_push = 1'b0;
    fe_set = 1'b0;
`ifdef UART_FIFO_PARITY_EN
    tx_par_d = tx_par_q;
    rx_par_d = rx_par_q;
    pe_set = 1'b0;
`endif

    // Prescaler: a bus write to either divisor byte restarts the count.
    tick = (presc_q == div_q);
    presc_d = tick ? 16'd0 : presc_q + 16'd1;
    if (w_en && address == 8'd0) div_d[7:0] = din;
    if (w_en && address == 8'd3) div_d[15:8] = din;
    if (w_en && (address == 8'd0 || address == 8'd3)) presc_d = 16'd0;

    tx_empty = (tx_wp_q == tx_rp_q);
    tx_full  = ((tx_wp_q - tx_rp_q) == DEPTH);
    rx_empty = (rx_wp_q == rx_rp_q);
    rx_full  = ((rx_wp_q - rx_rp_q) == DEPTH);
    tx_idle  = tx_empty && (tx_st_q == TX_IDLE);
    status   = {2'b00, tx_idle, pe_q, fe_q, ovr_q, ~tx_full, ~rx_empty};

    // TX: a new frame starts from IDLE or directly at the end of a stop bit.
    tx_start = tick && !tx_empty &&
               (tx_st_q == TX_IDLE || (tx_st_q == TX_STOP && tx_cnt_q == '0));
    tx_pop = tx_start;
    if (tick) begin
      case (tx_st_q)
        TX_START: begin
          if (tx_cnt_q == '0) begin
            tx_st_d = TX_DATA; tx_d = tx_sh_q[0]; tx_cnt_d = OS_LAST; tx_bit_d = 3'd0;
          end else tx_cnt_d = tx_cnt_q - OW'(1);
        end
        TX_DATA: begin
          if (tx_cnt_q == '0) begin
            tx_cnt_d = OS_LAST;
            if (tx_bit_q == BIT_LAST) begin
`ifdef UART_FIFO_PARITY_EN
              tx_st_d = TX_PARITY; tx_d = tx_par_q;
`else
              tx_st_d = TX_STOP; tx_d = 1'b1;
`endif
            end else begin
              tx_bit_d = tx_bit_q + 3'd1;
              tx_sh_d = tx_sh_q >> 1;
              tx_d = tx_sh_q[1];
            end
          end else tx_cnt_d = tx_cnt_q - OW'(1);
        end
        TX_PARITY: begin
          if (tx_cnt_q == '0) begin
            tx_st_d = TX_STOP; tx_d = 1'b1; tx_cnt_d = OS_LAST;
          end else tx_cnt_d = tx_cnt_q - OW'(1);
        end
        TX_STOP: begin
          if (tx_cnt_q == '0) tx_st_d = TX_IDLE;
          else tx_cnt_d = tx_cnt_q - OW'(1);
        end
        default: ;
      endcase
    end
    if (tx_start) begin
      tx_sh_d = tx_mem_q[tx_rp_q[AW-1:0]];
      tx_d = 1'b0; tx_st_d = TX_START; tx_cnt_d = OS_LAST;
`ifdef UART_FIFO_PARITY_EN
      tx_par_d = ^tx_mem_q[tx_rp_q[AW-1:0]];
`endif
    end
    tx_push = w_en && address == 8'd2 && (!tx_full || tx_pop);

    // RX
    if (tick) begin
      case (rx_st_q)
        RX_IDLE: if (!rx_s) begin rx_st_d = RX_START; rx_cnt_d = OS_HALF; end
        RX_START: begin
          if (rx_cnt_q == '0) begin
            rx_st_d = rx_s ? RX_IDLE : RX_DATA; rx_cnt_d = OS_LAST; rx_bit_d = 3'd0;
          end else rx_cnt_d = rx_cnt_q - OW'(1);
        end
        RX_DATA: begin
          if (rx_cnt_q == '0) begin
            rx_sh_d = {rx_s, rx_sh_q[DATA_BITS-1:1]};
            rx_cnt_d = OS_LAST;
            rx_bit_d = rx_bit_q + 3'd1;
`ifdef UART_FIFO_PARITY_EN
            if (rx_bit_q == BIT_LAST) rx_st_d = RX_PARITY;
`else
            if (rx_bit_q == BIT_LAST) rx_st_d = RX_STOP;
`endif
          end else rx_cnt_d = rx_cnt_q - OW'(1);
        end
        RX_PARITY: begin
          if (rx_cnt_q == '0) begin
`ifdef UART_FIFO_PARITY_EN
            rx_par_d = rx_s;
`endif
            rx_st_d = RX_STOP; rx_cnt_d = OS_LAST;
          end else rx_cnt_d = rx_cnt_q - OW'(1);
        end
        RX_STOP: begin
          if (rx_cnt_q == '0) begin
            if (rx_s) begin
              rx_push = 1'b1; rx_st_d = RX_IDLE;
`ifdef UART_FIFO_PARITY_EN
              pe_set = ^{rx_sh_q, rx_par_q};
`endif
            end else begin
              fe_set = 1'b1; rx_st_d = RX_WAIT;
            end
          end else rx_cnt_d = rx_cnt_q - OW'(1);
        end
        RX_WAIT: if (rx_s) rx_st_d = RX_IDLE;
        default: rx_st_d = RX_IDLE;
      endcase
    end
    rx_pop = r_en && address == 8'd2 && !rx_empty;
    // A bus pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    rx_push_ok = rx_push && (!rx_full || rx_pop);
    ovr_set = rx_push && !rx_push_ok;

    tx_wp_d = tx_push ? tx_wp_q + PW'(1) : tx_wp_q;
    tx_rp_d = tx_pop  ? tx_rp_q + PW'(1) : tx_rp_q;
    rx_wp_d = rx_push_ok ? rx_wp_q + PW'(1) : rx_wp_q;
    rx_rp_d = rx_pop ? rx_rp_q + PW'(1) : rx_rp_q;

    // Sticky flags: a hardware set wins over a same-cycle bus clear.
    clr = (w_en && address == 8'd1) ? din[4:2] : 3'b000;
    ovr_d = (ovr_q & ~clr[0]) | ovr_set;
    fe_d  = (fe_q & ~clr[1]) | fe_set;
`ifdef UART_FIFO_PARITY_EN
    pe_d  = (pe_q & ~clr[2]) | pe_set;
`else
    pe_d  = 1'b0;
`endif

    if (r_en) begin
      case (address)
        8'd0: dout_d = div_q[7:0];
        8'd1: dout_d = status;
        8'd2: dout_d = rx_pop ? 8'(rx_mem_q[rx_rp_q[AW-1:0]]) : 8'd0;
        8'd3: dout_d = div_q[15:8];
        default: dout_d = 8'd0;
      endcase
    end

    irq_d = (rx_wp_d != rx_rp_d) | ovr_d | fe_d | pe_d;
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wp_q[AW-1:0]] <= din[DATA_BITS-1:0];
    if (rx_push_ok) rx_mem_q[rx_wp_q[AW-1:0]] <= rx_sh_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= 16'(BAUD_RESET); presc_q <= '0; sync_q <= 2'b11;
      rx_st_q <= RX_IDLE; rx_cnt_q <= '0; rx_bit_q <= '0; rx_sh_q <= '0;
      tx_st_q <= TX_IDLE; tx_cnt_q <= '0; tx_bit_q <= '0; tx_sh_q <= '0;
      tx_q <= 1'b1; irq_q <= 1'b0; dout_q <= '0;
      ovr_q <= 1'b0; fe_q <= 1'b0; pe_q <= 1'b0;
      tx_wp_q <= '0; tx_rp_q <= '0; rx_wp_q <= '0; rx_rp_q <= '0;
`ifdef UART_FIFO_PARITY_EN
      tx_par_q <= 1'b0; rx_par_q <= 1'b0;
`endif
    end else begin
      div_q <= div_d; presc_q <= presc_d; sync_q <= sync_d;
      rx_st_q <= rx_st_d; rx_cnt_q <= rx_cnt_d; rx_bit_q <= rx_bit_d; rx_sh_q <= rx_sh_d;
      tx_st_q <= tx_st_d; tx_cnt_q <= tx_cnt_d; tx_bit_q <= tx_bit_d; tx_sh_q <= tx_sh_d;
      tx_q <= tx_d; irq_q <= irq_d; dout_q <= dout_d;
      ovr_q <= ovr_d; fe_q <= fe_d; pe_q <= pe_d;
      tx_wp_q <= tx_wp_d; tx_rp_q <= tx_rp_d; rx_wp_q <= rx_wp_d; rx_rp_q <= rx_rp_d;
`ifdef UART_FIFO_PARITY_EN
      tx_par_q <= tx_par_d; rx_par_q <= rx_par_d;
`endif
    end
  end

  assign tx   = tx_q;
  assign irq  = irq_q;
  assign dout = dout_q;
endmodule

// File: doc/uart_fifo.md
# uart_fifo

Parametrised buffered UART peripheral on the 8-bit memory-mapped I/O bus, with a runtime-programmable baud divisor and independent TX and RX FIFOs. It replaces the single-byte-buffer UART. It adds sticky error flags and configurable frame width and oversampling, so firmware can stream bursts without polling every byte.

## Interface
- DATA_BITS, 8: payload bits per frame; legal range 5..8.
- OVERSAMPLE, 16: sample ticks per bit; power of 2, at least 4.
- FIFO_DEPTH, 16: entries per FIFO; power of 2, at least 2.
- BAUD_RESET, 651: divisor loaded at reset. Tick period is BAUD_RESET+1 clk, giving 9600 baud at 100 MHz with OVERSAMPLE=16.
- clk, input, 1: clock.
- rst, input, 1: reset; synchronous, active-high.
- address, input, 8: register select.
- din, input, 8: write data.
- w_en, input, 1: write strobe, one cycle per access.
- r_en, input, 1: read strobe, one cycle per access.
- dout, output, 8: registered read data.
- rx, input, 1: asynchronous serial input, idle high.
- tx, output, 1: serial output, idle high.
- irq, output, 1: registered level; high when (rx FIFO not empty) OR (any sticky error flag set).

## Operation
- Register map:
  - addr 0: BAUD_LO, read/write; divisor bits [7:0].
  - addr 3: BAUD_HI, read/write; divisor bits [15:8].
  - addr 1: STATUS, read; write-1-to-clear on bits 2..4.
    - bit0 rx_avail.
    - bit1 tx_space.
    - bit2 rx_overrun, sticky.
    - bit3 frame_err, sticky.
    - bit4 parity_err, sticky.
    - bit5 tx_idle (FIFO empty and shifter idle).
    - bits 7:6 read 0.
  - addr 2: DATA. A write pushes din[DATA_BITS-1:0] to the TX FIFO. A read pops the RX FIFO; payload is zero-extended to 8 bits.
  - Any other address reads 0; writes to it are ignored.
- Bus access:
  - Read of an empty RX FIFO returns 0 and does not change any pointer.
  - Write to a full TX FIFO is dropped silently; tx_space was 0.
- Tick generator:
  - 16-bit prescaler counts 0..divisor and emits a one-clk tick when it equals the divisor.
  - Writing BAUD_LO or BAUD_HI clears the prescaler in the same cycle.
  - A divisor of 0 gives a tick every clk.
- RX path:
  - rx passes through a 2-flop synchronizer clocked every clk, reset to 1.
  - States: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_HIGH.
  - IDLE: on a tick with sync rx=0, go to START.
  - START: after OVERSAMPLE/2 ticks, re-check the line. If high, it is a glitch; return to IDLE. If low, go to DATA.
  - DATA: sample every OVERSAMPLE ticks, LSB first, for DATA_BITS samples.
  - STOP: sample at mid-bit.
    - High: push the word to the RX FIFO, go to IDLE.
    - Low: set frame_err, discard the word, go to WAIT_HIGH.
  - WAIT_HIGH: go to IDLE on the first tick with the line high.
  - Push to a full RX FIFO: set rx_overrun; the new word is dropped and stored data is kept.
- TX path:
  - States: IDLE, START, DATA, PARITY (macro only), STOP.
  - Each bit is held for exactly OVERSAMPLE ticks.
  - IDLE: on a tick with the TX FIFO not empty, pop the head word, drive tx=0, go to START.
  - DATA: shift LSB first.
  - STOP: drive tx=1. At the end of stop, return to IDLE. The next word may start on the following tick, giving back-to-back frames with no gap.
- Simultaneous events:
  - Bus pop and RX push on a full FIFO: both succeed, no overrun.
  - Bus push and TX pop on a full FIFO: both succeed.
  - Hardware setting an error flag and a bus write-1-to-clear of that flag in the same cycle: the set wins.
- Reset mid-frame: aborts both FIFOs and both shifters. tx goes to 1 on the next clk; no partial frame resumes.

## Timing
- Reset values:
  - tx=1, dout=0, irq=0.
  - Both FIFOs empty; all sticky flags 0.
  - Divisor=BAUD_RESET; prescaler=0.
  - Both FSMs in IDLE; synchronizer=1.
- dout is valid on the clk after the r_en cycle and holds until the next read strobe.
- STATUS and irq reflect FIFO state one clk after any push or pop.
- One bit time is (divisor+1)*OVERSAMPLE clk.
- TX start latency: from a DATA write to an idle shifter until the tx falling edge is at most divisor+2 clk.
- RX latency: from the stop-bit mid-point to rx_avail=1 is at most 2 clk. The synchronizer adds 2 clk of latency on rx.

## Configuration
- UART_FIFO_PARITY_EN defined:
  - An even-parity bit follows the data bits on TX.
  - RX checks the parity bit. On a mismatch it sets parity_err but still stores the word.
- UART_FIFO_PARITY_EN undefined:
  - No parity bit in either direction.
  - STATUS bit4 reads 0 and writing 1 to it has no effect.

## Test plan
- Reset, then read STATUS: 0x22 (tx_space=1, tx_idle=1, all others 0); BAUD_LO reads 0x8B and BAUD_HI reads 0x02; tx=1.
- Set divisor=3, write 0x55 then 0xA3 to DATA, no parity: tx shows two back-to-back 10-bit frames, LSB first, 64 clk per bit, with no idle gap.
- Loop tx to rx, write 17 bytes 0x00..0x10 with FIFO_DEPTH=16, and read nothing: the 17th frame sets rx_overrun and irq=1. The first 16 reads return 0x00..0x0F; the next read returns 0 with rx_avail=0.
- Drive an rx frame of 0x3C whose stop bit is low: frame_err=1 and no word is stored. Write 0x08 to STATUS: frame_err clears. A following valid frame of 0x3C is read back as 0x3C.
- Drive a 0.25-bit low pulse on idle rx: no START acceptance, no FIFO push, STATUS unchanged.
- With UART_FIFO_PARITY_EN, send 0x07 with odd (wrong) parity: parity_err=1 and DATA reads 0x07. Assert rst mid-TX frame: tx=1 on the next clk and STATUS=0x22.
